// File: rtl/spi_packet_formatter_if.sv
// Sample-input and byte-handshake bundle between the packet formatter and its neighbours.
// The formatter attaches as slave; the sensor/SPI-slave side attaches as master.
interface spi_packet_formatter_if #(
    parameter int NUM_WORDS = 3
);
    logic                      sample_valid;
    logic [16*NUM_WORDS-1:0]   sample_data;
    logic                      data_ready;
    logic [7:0]                tx_data;
    logic                      tx_ack;
    logic                      busy;
    logic [7:0]                drop_count;

    modport master (
        output sample_valid, sample_data, tx_ack,
        input  data_ready, tx_data, busy, drop_count
    );

    modport slave (
        input  sample_valid, sample_data, tx_ack,
        output data_ready, tx_data, busy, drop_count
    );
endinterface

// File: rtl/spi_packet_formatter.sv
// Frames multi-word sensor samples as header/payload/checksum byte packets for the SPI slave.
// Defining SPI_PKT_SEQ_EN inserts a wrapping sequence byte right after the header.
module spi_packet_formatter #(
    parameter int         NUM_WORDS = 3,
    parameter logic [7:0] HEADER    = 8'hAA
) (
    input logic                  clk,
    input logic                  rst_n,
    spi_packet_formatter_if.slave bus
);
`ifdef SPI_PKT_SEQ_EN
    localparam int HDR_LEN = 2;
`else
    localparam int HDR_LEN = 1;
`endif
    localparam int DATA_W  = 16 * NUM_WORDS;
    localparam int PKT_LEN = HDR_LEN + 2 * NUM_WORDS + 1;
    localparam int IDX_W   = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(PKT_LEN - 1);
    localparam logic [IDX_W-1:0] FIRST_PAYLOAD = IDX_W'(HDR_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t            state, next_state;
    logic [DATA_W-1:0] pending_data, active_data;
    logic              pending_valid;
    logic [IDX_W-1:0]  byte_idx, next_idx, payload_pos;
    logic [7:0]        checksum, payload_byte, next_byte;
    logic              data_ready_q;
    logic [7:0]        tx_data_q, drop_count_q;
    logic              ack_accept, final_ack, drop;
`ifdef SPI_PKT_SEQ_EN
    logic [7:0]        seq_num;
`endif

    // The LOAD cycle empties pending, so a strobe there is a refill, not an overwrite.
    assign ack_accept = (state == SEND) && bus.tx_ack;
    assign final_ack  = ack_accept && (byte_idx == LAST_IDX);
    assign drop       = bus.sample_valid && pending_valid && (state != LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (pending_valid) next_state = LOAD;
            LOAD:    next_state = SEND;
            SEND:    if (final_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        next_idx     = byte_idx + IDX_W'(1);
        payload_pos  = next_idx - FIRST_PAYLOAD;
        payload_byte = 8'h00;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (payload_pos == IDX_W'(2 * k))     payload_byte = active_data[16*k+8 +: 8];
            if (payload_pos == IDX_W'(2 * k + 1)) payload_byte = active_data[16*k +: 8];
        end
        next_byte = payload_byte;
        if (next_idx == LAST_IDX) next_byte = checksum;
`ifdef SPI_PKT_SEQ_EN
        if (next_idx == IDX_W'(1)) next_byte = seq_num;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_data  <= '0;
            pending_valid <= 1'b0;
            drop_count_q  <= 8'h00;
        end else begin
            if (bus.sample_valid) begin
                pending_data  <= bus.sample_data;
                pending_valid <= 1'b1;
            end else if (state == LOAD) begin
                pending_valid <= 1'b0;
            end
            if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'h01;
        end
    end

    // The checksum byte itself is never folded back into the running sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_data  <= '0;
            byte_idx     <= '0;
            checksum     <= 8'h00;
            tx_data_q    <= 8'h00;
            data_ready_q <= 1'b0;
        end else if (state == LOAD) begin
            active_data  <= pending_data;
            byte_idx     <= '0;
            checksum     <= HEADER;
            tx_data_q    <= HEADER;
            data_ready_q <= 1'b1;
        end else if (ack_accept) begin
            if (final_ack) begin
                data_ready_q <= 1'b0;
            end else begin
                byte_idx  <= next_idx;
                tx_data_q <= next_byte;
                if (next_idx != LAST_IDX) checksum <= checksum + next_byte;
            end
        end
    end

`ifdef SPI_PKT_SEQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_num <= 8'h00;
        end else if (final_ack) begin
            seq_num <= seq_num + 8'h01;
        end
    end
`endif

    assign bus.data_ready = data_ready_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.drop_count = drop_count_q;
    assign bus.busy       = (state != IDLE) || pending_valid;
endmodule

// File: tb/tb_spi_packet_formatter.sv
// Directed self-checking bench for spi_packet_formatter; also covers the SPI_PKT_SEQ_EN build.
module tb_spi_packet_formatter;
`ifdef SPI_PKT_SEQ_EN
    localparam int NW = 1;
`else
    localparam int NW = 2;
`endif
    localparam int DW = 16 * NW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_count = 0;
    int   check_count = 0;

    spi_packet_formatter_if #(.NUM_WORDS(NW)) bus ();

    spi_packet_formatter #(.NUM_WORDS(NW), .HEADER(8'hAA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, so outputs are read well clear of it.
    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic ack);
        bus.sample_valid = valid;
        bus.sample_data  = data;
        bus.tx_ack       = ack;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.tx_ack       = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitReady(input string tag, input int expected_cycles);
        int n = 0;
        while (!bus.data_ready && n < 10) begin
            applyStimulus(1'b0, '0, 1'b0);
            n++;
        end
        checkOutput(tag, n, expected_cycles);
    endtask

    task automatic ackExpect(input string tag, input logic [7:0] expected);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput({tag, "_rdy"}, {31'd0, bus.data_ready}, 32'd1);
        checkOutput(tag, {24'd0, bus.tx_data}, {24'd0, expected});
    endtask

    task automatic ackLast(input string tag);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput(tag, {31'd0, bus.data_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.tx_ack       = 1'b0;
        #12;
        checkOutput("rst_ready", {31'd0, bus.data_ready}, 32'd0);
        checkOutput("rst_tx", {24'd0, bus.tx_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_drop", {24'd0, bus.drop_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);

`ifdef SPI_PKT_SEQ_EN
        applyStimulus(1'b1, 16'h0102, 1'b0);
        waitReady("seq1_lat", 2);
        checkOutput("seq1_b0", {24'd0, bus.tx_data}, 32'hAA);
        ackExpect("seq1_b1", 8'h00);
        ackExpect("seq1_b2", 8'h01);
        ackExpect("seq1_b3", 8'h02);
        ackExpect("seq1_b4", 8'hAD);
        ackLast("seq1_end");
        applyStimulus(1'b1, 16'h0102, 1'b0);
        waitReady("seq2_lat", 2);
        checkOutput("seq2_b0", {24'd0, bus.tx_data}, 32'hAA);
        ackExpect("seq2_b1", 8'h01);
        ackExpect("seq2_b2", 8'h01);
        ackExpect("seq2_b3", 8'h02);
        ackExpect("seq2_b4", 8'hAE);
        ackLast("seq2_end");
        checkOutput("seq_busy", {31'd0, bus.busy}, 32'd0);
`else
        // Basic packet with a 20-cycle stall on the header byte.
        applyStimulus(1'b1, {16'h1234, 16'hABCD}, 1'b0);
        checkOutput("strobe_busy", {31'd0, bus.busy}, 32'd1);
        checkOutput("strobe_rdy", {31'd0, bus.data_ready}, 32'd0);
        waitReady("latency", 2);
        checkOutput("basic_b0", {24'd0, bus.tx_data}, 32'hAA);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("hold_b0", {23'd0, bus.data_ready, bus.tx_data}, 32'h1AA);
        end
        ackExpect("basic_b1", 8'hAB);
        ackExpect("basic_b2", 8'hCD);
        ackExpect("basic_b3", 8'h12);
        ackExpect("basic_b4", 8'h34);
        ackExpect("basic_b5", 8'h68);
        ackLast("basic_end");
        checkOutput("basic_busy", {31'd0, bus.busy}, 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("idle_ack_rdy", {31'd0, bus.data_ready}, 32'd0);
        checkOutput("idle_ack_busy", {31'd0, bus.busy}, 32'd0);

        // Overflow: second in-flight strobe fills pending, third overwrites it.
        applyStimulus(1'b1, {16'h1111, 16'h2222}, 1'b0);
        waitReady("ovf_lat", 2);
        applyStimulus(1'b1, {16'hDEAD, 16'hBEEF}, 1'b0);
        checkOutput("ovf_drop0", {24'd0, bus.drop_count}, 32'd0);
        applyStimulus(1'b1, {16'hF0F0, 16'h0F0F}, 1'b0);
        checkOutput("ovf_drop1", {24'd0, bus.drop_count}, 32'd1);
        checkOutput("ovf_b0", {24'd0, bus.tx_data}, 32'hAA);
        ackExpect("ovf_a_b1", 8'h22);
        ackExpect("ovf_a_b2", 8'h22);
        ackExpect("ovf_a_b3", 8'h11);
        ackExpect("ovf_a_b4", 8'h11);
        ackExpect("ovf_a_b5", 8'h10);
        ackLast("ovf_a_end");
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ovf_gap", {31'd0, bus.data_ready}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ovf_c_b0", {23'd0, bus.data_ready, bus.tx_data}, 32'h1AA);
        ackExpect("ovf_c_b1", 8'h0F);
        ackExpect("ovf_c_b2", 8'h0F);
        ackExpect("ovf_c_b3", 8'hF0);
        ackExpect("ovf_c_b4", 8'hF0);
        ackExpect("ovf_c_b5", 8'hA8);
        ackLast("ovf_c_end");
        checkOutput("ovf_drop_keep", {24'd0, bus.drop_count}, 32'd1);

        // Reset after byte 2 discards the packet and the drop counter.
        applyStimulus(1'b1, {16'h5555, 16'h6666}, 1'b0);
        waitReady("mid_lat", 2);
        ackExpect("mid_b1", 8'h66);
        ackExpect("mid_b2", 8'h66);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rdy", {31'd0, bus.data_ready}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("mid_rst_drop", {24'd0, bus.drop_count}, 32'd0);
        checkOutput("mid_rst_tx", {24'd0, bus.tx_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, {16'h0000, 16'h00FF}, 1'b0);
        waitReady("post_lat", 2);
        checkOutput("post_b0", {24'd0, bus.tx_data}, 32'hAA);
        ackExpect("post_b1", 8'h00);
        ackExpect("post_b2", 8'hFF);
        ackExpect("post_b3", 8'h00);
        ackExpect("post_b4", 8'h00);
        ackExpect("post_b5", 8'hA9);
        ackLast("post_end");

        // Strobe landing in the LOAD cycle refills pending without a drop.
        applyStimulus(1'b1, {16'h0102, 16'h0304}, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, {16'h8000, 16'h0080}, 1'b0);
        checkOutput("sim_b0", {23'd0, bus.data_ready, bus.tx_data}, 32'h1AA);
        checkOutput("sim_drop", {24'd0, bus.drop_count}, 32'd0);
        checkOutput("sim_busy", {31'd0, bus.busy}, 32'd1);
        ackExpect("sim_f_b1", 8'h03);
        ackExpect("sim_f_b2", 8'h04);
        ackExpect("sim_f_b3", 8'h01);
        ackExpect("sim_f_b4", 8'h02);
        ackExpect("sim_f_b5", 8'hB4);
        ackLast("sim_f_end");
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("sim_gap", {31'd0, bus.data_ready}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("sim_g_b0", {23'd0, bus.data_ready, bus.tx_data}, 32'h1AA);
        ackExpect("sim_g_b1", 8'h00);
        ackExpect("sim_g_b2", 8'h80);
        ackExpect("sim_g_b3", 8'h80);
        ackExpect("sim_g_b4", 8'h00);
        ackExpect("sim_g_b5", 8'hAA);
        ackLast("sim_g_end");
        checkOutput("sim_drop_end", {24'd0, bus.drop_count}, 32'd0);
        checkOutput("sim_busy_end", {31'd0, bus.busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/spi_packet_formatter.md
Name: spi_packet_formatter

Overview:
Upstream feeder for the MCU-facing SPI slave. Snapshots multi-word sensor samples and frames each one as a byte packet: header, big-endian payload, then checksum. Presents the packet one byte at a time on the slave's data_ready/tx_data/tx_ack byte handshake. Double-buffered, so a sample that arrives while a packet is in flight is held rather than corrupting the current packet.

Parameters:
- NUM_WORDS, 3, number of 16-bit words per sample (1..8).
- HEADER, 8'hAA, first byte of every packet.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  single-cycle strobe; sample_data valid this cycle
- sample_data  in  16*NUM_WORDS  word k at [16k+15:16k]
- data_ready  out  1  a packet byte is presented on tx_data
- tx_data  out  8  current packet byte; registered, never combinational from state
- tx_ack  in  1  one-cycle pulse: current byte consumed by the SPI slave
- busy  out  1  active packet in flight, or pending buffer occupied
- drop_count  out  8  saturating count of overwritten pending samples

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - data_ready=0, tx_data=8'h00, busy=0, drop_count=0.
  - pending_valid=0, byte_idx=0, checksum accumulator=0, state=IDLE.
- Packet format: PKT_LEN = 2 + 2*NUM_WORDS bytes.
  - Byte 0 is HEADER.
  - Then word 0 MSB, word 0 LSB, word 1 MSB, ..., word NUM_WORDS-1 LSB.
  - Last byte is the checksum: sum modulo 256 of all preceding bytes, header included.
- Pending buffer: any sample_valid loads pending and sets pending_valid.
  - If pending_valid is already 1 and pending is not being transferred this cycle: overwrite pending (latest sample wins) and increment drop_count, saturating at 255.
- Active buffer: holds the packet being sent. Only the IDLE->LOAD transfer writes it.
- FSM states and transitions:
  - IDLE: data_ready=0. If pending_valid, go to LOAD.
  - LOAD (1 cycle): copy pending to active, clear pending_valid, byte_idx<=0, tx_data<=HEADER, checksum<=HEADER. Next state SEND.
  - SEND: data_ready=1. On tx_ack with byte_idx<PKT_LEN-1: byte_idx++, load the next byte into tx_data on the same edge, and add it to checksum unless it is the checksum byte.
  - SEND: the byte after the last payload byte is the accumulated checksum.
  - SEND: on tx_ack with byte_idx==PKT_LEN-1, go to IDLE with data_ready<=0 on the same edge.
- Latency:
  - sample_valid in IDLE with empty pending: data_ready=1 three edges later (pending, LOAD, SEND).
  - tx_ack to new tx_data: exactly 1 cycle. tx_data is stable for the whole time data_ready=1 between acks.
- Simultaneous events:
  - sample_valid in the same cycle as the LOAD transfer: the new sample goes into pending, pending_valid stays 1, no drop counted.
  - tx_ack while not in SEND: ignored.
  - tx_ack held high for several cycles: each high cycle counts as one ack. The slave guarantees single-cycle pulses.
- Back-to-back packets: after the last ack, IDLE and then LOAD again if pending_valid is set. This leaves data_ready low for at least 2 cycles between packets, so the slave sees a new data_ready rise.
- busy = (state != IDLE) | pending_valid.
- Reset mid-packet: everything returns to reset values immediately and the in-flight packet is discarded.

Optional Feature:
- Macro: SPI_PKT_SEQ_EN.
- When defined: an 8-bit sequence byte is inserted immediately after HEADER.
  - The sequence byte is included in the checksum.
  - PKT_LEN = 3 + 2*NUM_WORDS.
  - The sequence value resets to 0 and increments, wrapping 255->0, when each packet's final ack is accepted.
- When undefined: no sequence byte, no counter logic, PKT_LEN = 2 + 2*NUM_WORDS.

Test Plan:
- Basic packet (NUM_WORDS=2, no macro): sample_valid with words {0x1234, 0xABCD}, where word0=0xABCD. Ack each byte -> tx_data sequence AA, AB, CD, 12, 34, 68. data_ready drops on the edge of the 6th ack.
- Latency and stability: single sample, tx_ack delayed 20 cycles -> data_ready rises 3 edges after the strobe and tx_data holds 0xAA all 20 cycles. Each later byte appears 1 cycle after its ack.
- Overflow: three sample_valid strobes during one in-flight packet -> drop_count=1. The second packet carries the third sample.
- Simultaneous load and strobe: sample_valid in the LOAD cycle -> drop_count stays 0. A second packet with the new data follows after data_ready has been low for at least 2 cycles.
- Reset mid-packet: assert rst_n=0 after byte 2 is acked -> data_ready=0, busy=0, drop_count=0 immediately. A fresh sample afterwards starts again at 0xAA.
- SPI_PKT_SEQ_EN defined (NUM_WORDS=1, word 0x0102): two packets -> AA, 00, 01, 02, AD, then AA, 01, 01, 02, AE.
